// File: rtl/btn_pkg.sv
// Shared definitions for the button front end.
//   - per-channel FSM state encoding
//   - default timing constants for 40 Hz sampling from a 50 MHz clock
//   - small elaboration-time helper for sizing the hold counter
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HOLD   = 2'd3
    } btn_state_e;

    // 50 MHz / 1_250_000 = 40 Hz sample tick
    localparam int unsigned DIV_40HZ_AT_50MHZ = 32'd1250000;
    // 20 ticks at 40 Hz = 500 ms before the first repeat
    localparam int unsigned REP_DLY_500MS     = 32'd20;
    // 4 ticks at 40 Hz = 100 ms between repeats
    localparam int unsigned REP_INT_100MS     = 32'd4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_rep_ch.sv
// One button channel: tick-rate two-stage sampler, debounced level,
// press detection and auto-repeat FSM with its hold counter.
// Ports:
//   CLK, RST   - system clock, asynchronous active-high reset
//   tick_i     - one-clock sample strobe from the shared divider
//   p_i        - normalised raw pin, 1 = pressed
//   bout_o     - one-clock pulse on press or repeat
//   brep_o     - one-clock pulse on repeat only
//   blvl_o     - debounced pressed level
module btn_rep_ch
    import btn_pkg::*;
#(
    parameter int unsigned REP_DLY = REP_DLY_500MS,
    parameter int unsigned REP_INT = REP_INT_100MS,
    parameter bit          REP_EN  = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic tick_i,
    input  logic p_i,
    output logic bout_o,
    output logic brep_o,
    output logic blvl_o
);

    localparam int unsigned HC_MAX = max_u(REP_DLY, REP_INT);
    localparam int unsigned HCW    = $clog2(HC_MAX + 32'd1);
    localparam logic [HCW-1:0] DLY_LAST = HCW'(REP_DLY - 32'd1);
    localparam logic [HCW-1:0] INT_LAST = HCW'(REP_INT - 32'd1);

    btn_state_e     state_q, state_d;
    logic [HCW-1:0] hc_q, hc_d;
    logic           s1_q, s1_d;
    logic           s2_q, s2_d;
    logic           bout_q, bout_d;
    logic           brep_q, brep_d;
    logic           blvl_q, blvl_d;

    // Next-state logic: sampler, debounced level, FSM and hold counter.
    // All FSM decisions use the sample taken on the previous tick (s1_q).
    always_comb begin
        s1_d    = s1_q;
        s2_d    = s2_q;
        blvl_d  = blvl_q;
        state_d = state_q;
        hc_d    = hc_q;
        bout_d  = 1'b0;
        brep_d  = 1'b0;

        if (tick_i) begin
            s1_d   = p_i;
            s2_d   = s1_q;
            // Level of the two samples as they will stand after this tick,
            // so it rises together with the press pulse.
            blvl_d = p_i & s1_q;
        end else begin
            blvl_d = blvl_q;
        end

        case (state_q)
            IDLE: begin
                if (tick_i && s1_q && !s2_q) begin
                    bout_d  = 1'b1;
                    hc_d    = '0;
                    state_d = REP_EN ? DELAY : HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            DELAY: begin
                if (tick_i) begin
                    if (!s1_q) begin
                        state_d = IDLE;
                        hc_d    = '0;
                    end else if (hc_q == DLY_LAST) begin
                        bout_d  = 1'b1;
                        brep_d  = 1'b1;
                        hc_d    = '0;
                        state_d = REPEAT;
                    end else begin
                        hc_d = hc_q + HCW'(1);
                    end
                end else begin
                    state_d = DELAY;
                end
            end
            REPEAT: begin
                if (tick_i) begin
                    if (!s1_q) begin
                        state_d = IDLE;
                        hc_d    = '0;
                    end else if (hc_q == INT_LAST) begin
                        bout_d = 1'b1;
                        brep_d = 1'b1;
                        hc_d   = '0;
                    end else begin
                        hc_d = hc_q + HCW'(1);
                    end
                end else begin
                    state_d = REPEAT;
                end
            end
            HOLD: begin
                if (tick_i && !s1_q) begin
                    state_d = IDLE;
                    hc_d    = '0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                hc_d    = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any hold with no pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            hc_q    <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            bout_q  <= 1'b0;
            brep_q  <= 1'b0;
            blvl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            bout_q  <= bout_d;
            brep_q  <= brep_d;
            blvl_q  <= blvl_d;
        end
    end

    assign bout_o = bout_q;
    assign brep_o = brep_q;
    assign blvl_o = blvl_q;

endmodule

// File: rtl/btn_repeat_in.sv
// N-channel debounced button front end with press and auto-repeat pulses.
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-high reset
//   BIN  - raw button pins (polarity set by ACTIVE_LOW)
//   BOUT - one-clock pulse per channel on press or repeat
//   BREP - one-clock pulse per channel on repeat only
//   BLVL - debounced pressed level, 1 = pressed
module btn_repeat_in
    import btn_pkg::*;
#(
    parameter int unsigned   N          = 32'd3,
    parameter int unsigned   DIV        = DIV_40HZ_AT_50MHZ,
    parameter bit            ACTIVE_LOW = 1'b1,
    parameter logic [N-1:0]  REP_EN     = {N{1'b1}},
    parameter int unsigned   REP_DLY    = REP_DLY_500MS,
    parameter int unsigned   REP_INT    = REP_INT_100MS
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] BIN,
    output logic [N-1:0] BOUT,
    output logic [N-1:0] BREP,
    output logic [N-1:0] BLVL
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 32'd1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_s;
    logic [N-1:0]  p_s;

    assign tick_s = (cnt_q == CNT_LAST);
    assign p_s    = ACTIVE_LOW ? ~BIN : BIN;

    // Divider next value: wrap to zero after the tick cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Shared sample-tick divider register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        btn_rep_ch #(
            .REP_DLY (REP_DLY),
            .REP_INT (REP_INT),
            .REP_EN  (REP_EN[g])
        ) u_ch (
            .CLK    (CLK),
            .RST    (RST),
            .tick_i (tick_s),
            .p_i    (p_s[g]),
            .bout_o (BOUT[g]),
            .brep_o (BREP[g]),
            .blvl_o (BLVL[g])
        );
    end

endmodule

// File: tb/tb_btn_repeat_in.sv
// Directed bench for btn_repeat_in with DIV=4, N=3, REP_DLY=3, REP_INT=2.
// e counts rising edges since reset release; with DIV=4 a pulse caused by
// tick k is visible while e == 4*k.
module tb_btn_repeat_in;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] bin = 3'b111;
    logic [2:0] bin_hi;
    logic [2:0] bout, brep, blvl;
    logic [2:0] hbout, hbrep, hblvl;

    int e = 0;
    int n_tests = 0;
    int n_fail  = 0;

    int bo_e [3][16];
    int br_e [3][16];
    int bo_n [3];
    int br_n [3];
    int bl_n [3];
    int bl_first [3];
    int hb_e0, hb_n0, hl_n0, hr_n0;

    assign bin_hi = ~bin;

    always #5 clk = ~clk;

    btn_repeat_in #(
        .N(3), .DIV(4), .ACTIVE_LOW(1'b1), .REP_EN(3'b110), .REP_DLY(3), .REP_INT(2)
    ) dut (
        .CLK(clk), .RST(rst), .BIN(bin), .BOUT(bout), .BREP(brep), .BLVL(blvl)
    );

    btn_repeat_in #(
        .N(3), .DIV(4), .ACTIVE_LOW(1'b0), .REP_EN(3'b000), .REP_DLY(3), .REP_INT(2)
    ) dut_hi (
        .CLK(clk), .RST(rst), .BIN(bin_hi), .BOUT(hbout), .BREP(hbrep), .BLVL(hblvl)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) e <= 0;
        else     e <= e + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                bo_n[c]     <= 0;
                br_n[c]     <= 0;
                bl_n[c]     <= 0;
                bl_first[c] <= -1;
            end
            hb_n0 <= 0; hl_n0 <= 0; hr_n0 <= 0; hb_e0 <= -1;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (bout[c]) begin
                    if (bo_n[c] < 16) bo_e[c][bo_n[c]] <= e;
                    bo_n[c] <= bo_n[c] + 1;
                end
                if (brep[c]) begin
                    if (br_n[c] < 16) br_e[c][br_n[c]] <= e;
                    br_n[c] <= br_n[c] + 1;
                end
                if (blvl[c]) begin
                    if (bl_n[c] == 0) bl_first[c] <= e;
                    bl_n[c] <= bl_n[c] + 1;
                end
            end
            if (hbout[0]) begin
                if (hb_n0 == 0) hb_e0 <= e;
                hb_n0 <= hb_n0 + 1;
            end
            if (hbrep[0]) hr_n0 <= hr_n0 + 1;
            if (hblvl[0]) hl_n0 <= hl_n0 + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic wait_e(input int t);
        int k = 0;
        while (e < t && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("sync", e, t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bin = 3'b111;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int exp_bo1 [6] = '{8, 20, 28, 36, 44, 52};

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_bout", int'(bout), 0);
        check("rst_brep", int'(brep), 0);
        check("rst_blvl", int'(blvl), 0);
        check("rst_hi_out", int'({hbout, hbrep, hblvl}), 0);
        rst = 1'b0;

        // Clean press on ch0 without repeat; dut_hi sees the same with high polarity
        do_reset();
        wait_e(1);  bin[0] = 1'b0;
        wait_e(9);  bin[0] = 1'b1;
        wait_e(24);
        check("s1_bout0_n", bo_n[0], 1);
        check("s1_bout0_e", bo_e[0][0], 8);
        check("s1_brep0_n", br_n[0], 0);
        check("s1_blvl0_n", bl_n[0], 4);
        check("s1_blvl0_first", bl_first[0], 8);
        check("s1_other_n", bo_n[1] + bo_n[2], 0);
        check("s6_hi_bout_n", hb_n0, 1);
        check("s6_hi_bout_e", hb_e0, 8);
        check("s6_hi_brep_n", hr_n0, 0);
        check("s6_hi_blvl_n", hl_n0, 4);

        // Long hold on ch1 with repeat
        do_reset();
        wait_e(1);  bin[1] = 1'b0;
        wait_e(49); bin[1] = 1'b1;
        wait_e(70);
        check("s2_bout1_n", bo_n[1], 6);
        check("s2_brep1_n", br_n[1], 5);
        for (int k = 0; k < 6; k++) check($sformatf("s2_bout1_e%0d", k), bo_e[1][k], exp_bo1[k]);
        for (int k = 0; k < 5; k++) check($sformatf("s2_brep1_e%0d", k), br_e[1][k], exp_bo1[k+1]);
        check("s2_other_n", bo_n[0] + bo_n[2], 0);

        // Bounce on ch2 then a short stable hold
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            wait_e(k);
            bin[2] = (k % 2 == 1) ? 1'b0 : 1'b1;
        end
        wait_e(7);  bin[2] = 1'b0;
        wait_e(13); bin[2] = 1'b1;
        wait_e(30);
        check("s3_bout2_n", bo_n[2], 1);
        check("s3_bout2_e", bo_e[2][0], 8);
        check("s3_brep2_n", br_n[2], 0);

        // All three pressed on the same clock
        do_reset();
        wait_e(1);  bin = 3'b000;
        wait_e(8);
        check("s4_bout_all", int'(bout), 7);
        check("s4_brep_none", int'(brep), 0);
        wait_e(9);  bin = 3'b111;
        wait_e(30);
        check("s4_bout_total", bo_n[0] + bo_n[1] + bo_n[2], 3);

        // Reset asserted while ch1 is repeating, button still held afterwards
        do_reset();
        wait_e(1);  bin[1] = 1'b0;
        wait_e(20);
        check("s5_rep_pulse", int'({bout[1], brep[1]}), 3);
        wait_e(22);
        check("s5_lvl_before", int'(blvl[1]), 1);
        rst = 1'b1;
        #1;
        check("s5_async_out", int'({bout, brep, blvl}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_e(7);
        check("s5_no_early", bo_n[1], 0);
        wait_e(9);  bin[1] = 1'b1;
        wait_e(30);
        check("s5_bout1_n", bo_n[1], 1);
        check("s5_bout1_e", bo_e[1][0], 8);
        check("s5_brep1_n", br_n[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
